// File: rtl/vga_timing_compositor.sv
// vga_timing_compositor
// Programmable VGA sync/display-enable generator with per-pixel coordinate
// requests and a fixed-priority compositor over NLAYERS layer colour streams.
// Timing inputs are captured into shadow registers once per frame.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_INIT | first cycle after reset: load shadows, counters held at 0
// S_RUN  | counters free-running, shadows reload at end of each frame
module vga_timing_compositor #(
  parameter int          CW        = 12,
  parameter int          NLAYERS   = 4,
  parameter int          LAYER_LAT = 1,
  parameter logic [23:0] BG_COLOR  = 24'h000000,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CW-1:0]         h_total,
  input  logic [CW-1:0]         h_sync,
  input  logic [CW-1:0]         h_start,
  input  logic [CW-1:0]         h_end,
  input  logic [CW-1:0]         v_total,
  input  logic [CW-1:0]         v_sync,
  input  logic [CW-1:0]         v_start,
  input  logic [CW-1:0]         v_end,
  input  logic [24*NLAYERS-1:0] layer_rgb,
  input  logic [NLAYERS-1:0]    layer_valid,
  output logic [CW-1:0]         pixel_x,
  output logic [CW-1:0]         pixel_y,
  output logic                  pix_req,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state_q, state_d;

  logic [CW-1:0] h_total_s, h_sync_s, h_start_s, h_end_s;
  logic [CW-1:0] v_total_s, v_sync_s, v_start_s, v_end_s;
  logic [CW-1:0] h_count, v_count;
  logic          h_wrap, v_wrap, ld_shadow;

  logic          h_act, v_act, req_d, ls_d, fs_d, hs_d, vs_d;
  logic [CW-1:0] px_d, py_d;

  // index 0 is the stage-0 register; the last index drives the pins
  logic [LAYER_LAT+1:0] hs_pipe, vs_pipe, de_pipe;
  logic [23:0]          sel_rgb, rgb_q;

  // Next state and shadow-load decision; reload coincides with the frame wrap
  always_comb begin
    state_d   = state_q;
    ld_shadow = 1'b0;
    h_wrap    = (h_count == h_total_s);
    v_wrap    = (v_count == v_total_s);
    case (state_q)
      S_INIT: begin
        state_d   = S_RUN;
        ld_shadow = 1'b1;
      end
      S_RUN:   ld_shadow = h_wrap && v_wrap;
      default: state_d = S_INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // Shadow timing registers, captured at init and at every frame boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total_s <= '0; h_sync_s <= '0; h_start_s <= '0; h_end_s <= '0;
      v_total_s <= '0; v_sync_s <= '0; v_start_s <= '0; v_end_s <= '0;
    end else if (ld_shadow) begin
      h_total_s <= h_total; h_sync_s <= h_sync; h_start_s <= h_start; h_end_s <= h_end;
      v_total_s <= v_total; v_sync_s <= v_sync; v_start_s <= v_start; v_end_s <= v_end;
    end
  end

  // Horizontal/vertical counters; held at 0 during the init cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (state_q == S_RUN) begin
      if (h_wrap) begin
        h_count <= '0;
        v_count <= v_wrap ? '0 : v_count + CW'(1);
      end else begin
        h_count <= h_count + CW'(1);
      end
    end
  end

  // Region decode and coordinate generation from the current count
  always_comb begin
    h_act = (h_count >= h_start_s) && (h_count < h_end_s);
    v_act = (v_count >= v_start_s) && (v_count < v_end_s);
    req_d = h_act && v_act;
    px_d  = req_d ? h_count - h_start_s : '0;
    py_d  = req_d ? v_count - v_start_s : '0;
    ls_d  = req_d && (px_d == '0);
    fs_d  = ls_d && (py_d == '0);
    hs_d  = (h_count < h_sync_s);
    vs_d  = (v_count < v_sync_s);
  end

  // Stage-0 request outputs and sync/de delay line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_req     <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
      de_pipe     <= '0;
    end else begin
      pix_req     <= req_d;
      pixel_x     <= px_d;
      pixel_y     <= py_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
      hs_pipe     <= {hs_pipe[LAYER_LAT:0], hs_d};
      vs_pipe     <= {vs_pipe[LAYER_LAT:0], vs_d};
      de_pipe     <= {de_pipe[LAYER_LAT:0], req_d};
    end
  end

  // Fixed priority: lowest valid layer index wins, else background
  always_comb begin
    sel_rgb = BG_COLOR;
    for (int i = NLAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i]) sel_rgb = layer_rgb[24*i +: 24];
    end
  end

  // Output colour register; de_pipe[LAYER_LAT] lines up with the layer data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                rgb_q <= '0;
    else if (de_pipe[LAYER_LAT]) rgb_q <= sel_rgb;
    else                         rgb_q <= '0;
  end

  assign vga_hs = hs_pipe[LAYER_LAT+1] ? HS_POL : ~HS_POL;
  assign vga_vs = vs_pipe[LAYER_LAT+1] ? VS_POL : ~VS_POL;
  assign vga_de = de_pipe[LAYER_LAT+1];
  assign vga_r  = rgb_q[23:16];
  assign vga_g  = rgb_q[15:8];
  assign vga_b  = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_compositor.sv
// Scoreboard bench for vga_timing_compositor: a frame-level reference model
// enumerates every pixel position of each frame from the timing values in
// force at that frame's start, expected responses are queued per cycle and a
// monitor compares them with the DUT.
module tb_vga_timing_compositor;

  localparam int          CW      = 12;
  localparam int          NL      = 4;
  localparam int          LAT     = 1;
  localparam int          OUT_LAT = 2 + LAT;
  localparam logic [23:0] BG      = 24'h204080;
  localparam bit          HSP     = 1'b0;
  localparam bit          VSP     = 1'b0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CW-1:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
  logic [24*NL-1:0] layer_rgb;
  logic [NL-1:0]    layer_valid;
  logic [CW-1:0]    pixel_x, pixel_y;
  logic             pix_req, line_start, frame_start, vga_hs, vga_vs, vga_de;
  logic [7:0]       vga_r, vga_g, vga_b;

  vga_timing_compositor #(
    .CW(CW), .NLAYERS(NL), .LAYER_LAT(LAT), .BG_COLOR(BG), .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .layer_rgb(layer_rgb), .layer_valid(layer_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_req(pix_req),
    .line_start(line_start), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs, vs, de, ls, fs;
    logic [CW-1:0] px, py;
  } pos_t;
  typedef struct packed {
    logic hs, vs, de;
    logic [23:0] rgb;
  } out_t;
  typedef struct packed {
    logic req, ls, fs;
    logic [CW-1:0] px, py;
  } req_t;

  pos_t pos_q[$];
  out_t out_q[$];
  req_t req_q[$];

  int errors = 0;
  int checks = 0;
  int n = 0;
  int next_frame = 0;
  int rand_layers = 1;
  int sess_cyc = 0;
  int first_fs = -1;
  int last_fs = -1;
  int fs_gap = -1;
  int fs_count = 0;
  int de_count = 0;
  int req_count = 0;
  int fs_powerup = -1;

  // Append every position of one frame, using the timing inputs driven now
  task automatic append_frame();
    int ht, hsw, hst, hen, vt, vsw, vst, ven;
    pos_t p;
    ht = int'(h_total); hsw = int'(h_sync); hst = int'(h_start); hen = int'(h_end);
    vt = int'(v_total); vsw = int'(v_sync); vst = int'(v_start); ven = int'(v_end);
    for (int v = 0; v <= vt; v++) begin
      for (int h = 0; h <= ht; h++) begin
        p.hs = (h < hsw);
        p.vs = (v < vsw);
        p.de = (h >= hst) && (h < hen) && (v >= vst) && (v < ven);
        p.px = p.de ? CW'(h - hst) : '0;
        p.py = p.de ? CW'(v - vst) : '0;
        p.ls = p.de && (h == hst);
        p.fs = p.ls && (v == vst);
        pos_q.push_back(p);
      end
    end
    next_frame += (ht + 1) * (vt + 1);
  endtask

  function automatic logic [23:0] pick(input logic [NL-1:0] lv, input logic [24*NL-1:0] lr);
    logic [23:0] c;
    bit found;
    c = BG;
    found = 0;
    for (int i = 0; i < NL; i++) begin
      if (!found && lv[i]) begin
        c = lr[24*i +: 24];
        found = 1;
      end
    end
    return c;
  endfunction

  // Drive layer inputs for the coming edge and queue what that edge must produce
  task automatic drive_and_push();
    out_t o;
    req_t r;
    pos_t p;
    if (rand_layers != 0) begin
      layer_valid = NL'($urandom);
      for (int i = 0; i < NL; i++) layer_rgb[24*i +: 24] = 24'($urandom);
    end
    if (n == next_frame) append_frame();
    if (n >= 1) begin
      p = pos_q[n-1];
      r = '{req: p.de, ls: p.ls, fs: p.fs, px: p.px, py: p.py};
    end else begin
      r = '0;
    end
    req_q.push_back(r);
    if (n >= OUT_LAT) begin
      p = pos_q[n-OUT_LAT];
      o.hs  = p.hs ? HSP : ~HSP;
      o.vs  = p.vs ? VSP : ~VSP;
      o.de  = p.de;
      o.rgb = p.de ? pick(layer_valid, layer_rgb) : 24'h0;
    end else begin
      o = '{hs: ~HSP, vs: ~VSP, de: 1'b0, rgb: 24'h0};
    end
    out_q.push_back(o);
    n++;
  endtask

  task automatic run(input int cyc);
    for (int k = 0; k < cyc; k++) begin
      drive_and_push();
      @(negedge clk);
    end
  endtask

  task automatic release_session();
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    next_frame = 0;
    pos_q.delete();
    out_q.delete();
    req_q.delete();
    sess_cyc = 0;
    first_fs = -1;
    last_fs = -1;
    fs_gap = -1;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    out_t go;
    req_t gr;
    go = '{hs: vga_hs, vs: vga_vs, de: vga_de, rgb: {vga_r, vga_g, vga_b}};
    gr = '{req: pix_req, ls: line_start, fs: frame_start, px: pixel_x, py: pixel_y};
    checks++;
    if (go !== {~HSP, ~VSP, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL %s_out got=%h expected=%h", name, go, {~HSP, ~VSP, 1'b0, 24'h0});
    end
    checks++;
    if (gr !== '0) begin
      errors++;
      $display("FAIL %s_req got=%h expected=0", name, gr);
    end
  endtask

  // Monitor: pop expectations one edge at a time and compare, plus running tallies
  initial begin
    out_t eo, go;
    req_t er, gr;
    forever begin
      @(posedge clk);
      #1;
      sess_cyc++;
      if (frame_start) begin
        fs_count++;
        if (first_fs < 0) first_fs = sess_cyc;
        if (last_fs >= 0) fs_gap = sess_cyc - last_fs;
        last_fs = sess_cyc;
      end
      if (vga_de) de_count++;
      if (pix_req) req_count++;
      if (out_q.size() > 0) begin
        eo = out_q.pop_front();
        go = '{hs: vga_hs, vs: vga_vs, de: vga_de, rgb: {vga_r, vga_g, vga_b}};
        checks++;
        if (go !== eo) begin
          errors++;
          $display("FAIL out cyc=%0d got hs=%b vs=%b de=%b rgb=%h expected hs=%b vs=%b de=%b rgb=%h",
                   sess_cyc, go.hs, go.vs, go.de, go.rgb, eo.hs, eo.vs, eo.de, eo.rgb);
        end
      end
      if (req_q.size() > 0) begin
        er = req_q.pop_front();
        gr = '{req: pix_req, ls: line_start, fs: frame_start, px: pixel_x, py: pixel_y};
        checks++;
        if (gr !== er) begin
          errors++;
          $display("FAIL req cyc=%0d got req=%b ls=%b fs=%b x=%0d y=%0d expected req=%b ls=%b fs=%b x=%0d y=%0d",
                   sess_cyc, gr.req, gr.ls, gr.fs, gr.px, gr.py, er.req, er.ls, er.fs, er.px, er.py);
        end
      end
    end
  end

  initial begin
    h_total = 9; h_sync = 2; h_start = 3; h_end = 8;
    v_total = 5; v_sync = 1; v_start = 2; v_end = 4;
    layer_rgb = '0;
    layer_valid = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");

    // power-up: three default frames with random layers
    release_session();
    run(185);
    check_int("first_fs_powerup", first_fs, 2*10 + 3 + 2);
    check_int("fs_period_60", fs_gap, 60);
    fs_powerup = first_fs;

    // priority: layer1 beats layer2; then nothing valid gives background
    rand_layers = 0;
    layer_valid = 4'b0110;
    layer_rgb = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h0F0F0F};
    run(60);
    layer_valid = 4'b0000;
    run(60);
    rand_layers = 1;

    // shadow reload: change h_total mid-frame
    h_total = 11;
    run(200);
    check_int("fs_period_72", fs_gap, 72);

    // degenerate horizontal region
    h_total = 9;
    h_start = 5;
    h_end = 5;
    run(200);
    fs_count = 0;
    de_count = 0;
    req_count = 0;
    run(120);
    check_int("degen_fs", fs_count, 0);
    check_int("degen_de", de_count, 0);
    check_int("degen_req", req_count, 0);

    // restore, then align to pixel (2,1) of a default frame and reset between edges
    h_start = 3;
    h_end = 8;
    run(next_frame - n);
    run(next_frame - n);
    run(13);
    #1;
    reset_n = 1'b0;
    out_q.delete();
    req_q.delete();
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    release_session();
    run(130);
    check_int("first_fs_after_reset", first_fs, fs_powerup);
    check_int("fs_period_after_reset", fs_gap, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
